// File: rtl/alu_muldiv_seq.sv
// Registered ALU with an iterative unsigned multiply/divide unit and HI/LO registers.
// Define ALU_DIV_EN to build the restoring divider (DIVU); otherwise op 14 behaves as undefined.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             n,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
`ifdef ALU_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  logic [1:0]       state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;

  assign in_ready = (state == IDLE);
  assign shamt    = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (opcode)
      5'd0:    alu_res = a + b;
      5'd1:    alu_res = a - b;
      5'd2:    alu_res = a & b;
      5'd3:    alu_res = a | b;
      5'd4:    alu_res = a ^ b;
      5'd5:    alu_res = ~(a | b);
      5'd6:    alu_res = a << shamt;
      5'd7:    alu_res = a >> shamt;
      5'd8:    alu_res = $signed(a) >>> shamt;
      5'd9:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      5'd10:   alu_res = a;
      5'd11:   alu_res = b;
      5'd12:   alu_res = b + WIDTH'(8);
      5'd15:   alu_res = hi;
      5'd16:   alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // Shift-add: {work_hi,work_lo} holds partial product and the remaining multiplier bits.
  always_comb begin
    mul_sum     = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], work_lo[WIDTH-1:1]};
  end

`ifdef ALU_DIV_EN
  logic             dz_q;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] div_hi_next;
  logic [WIDTH-1:0] div_lo_next;

  assign dz = dz_q;

  // Restoring divide: work_hi is the remainder, work_lo shifts dividend out and quotient in.
  // A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
  always_comb begin
    div_shift   = {work_hi, work_lo[WIDTH-1]};
    div_diff    = div_shift - {1'b0, operand};
    div_fits    = ~div_diff[WIDTH];
    div_hi_next = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_next = {work_lo[WIDTH-2:0], div_fits};
  end
`else
  assign dz = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      work_hi   <= '0;
      work_lo   <= '0;
      operand   <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      z         <= 1'b0;
      n         <= 1'b0;
      hi        <= '0;
      lo        <= '0;
`ifdef ALU_DIV_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (opcode == 5'd13) begin
              state   <= MUL;
              cnt     <= '0;
              work_hi <= '0;
              work_lo <= a;
              operand <= b;
`ifdef ALU_DIV_EN
            end else if (opcode == 5'd14) begin
              state   <= DIV;
              cnt     <= '0;
              work_hi <= '0;
              work_lo <= a;
              operand <= b;
`endif
            end else begin
              out       <= alu_res;
              z         <= (alu_res == '0);
              n         <= alu_res[WIDTH-1];
              out_valid <= 1'b1;
`ifdef ALU_DIV_EN
              dz_q      <= 1'b0;
`endif
            end
          end
        end
        MUL: begin
          cnt     <= cnt + 1'b1;
          work_hi <= mul_hi_next;
          work_lo <= mul_lo_next;
          if (cnt == LAST_STEP) begin
            hi        <= mul_hi_next;
            lo        <= mul_lo_next;
            out       <= mul_lo_next;
            z         <= (mul_lo_next == '0);
            n         <= mul_lo_next[WIDTH-1];
            out_valid <= 1'b1;
            state     <= IDLE;
`ifdef ALU_DIV_EN
            dz_q      <= 1'b0;
`endif
          end
        end
`ifdef ALU_DIV_EN
        DIV: begin
          cnt     <= cnt + 1'b1;
          work_hi <= div_hi_next;
          work_lo <= div_lo_next;
          if (cnt == LAST_STEP) begin
            hi        <= div_hi_next;
            lo        <= div_lo_next;
            out       <= div_lo_next;
            z         <= (div_lo_next == '0);
            n         <= div_lo_next[WIDTH-1];
            dz_q      <= (operand == '0);
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed self-checking bench for alu_muldiv_seq (WIDTH=32); honours ALU_DIV_EN.
module tb_alu_muldiv_seq;
  localparam int WIDTH = 32;
  localparam int NV = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             z;
  logic             n;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        z;
    logic        n;
  } vec_t;

  vec_t vecs[NV];

  alu_muldiv_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out(out),
    .z(z), .n(n), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for in_ready, presents one request for a single edge, then drops in_valid.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) checkOutput("in_ready timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    opcode = op;
    a = va;
    b = vb;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int cycles, output int ready_high);
    cycles = 0;
    ready_high = 0;
    while (!out_valid && cycles < 100) begin
      if (in_ready) ready_high++;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int rh;
    int pulses;
    logic [31:0] got0;
    logic [31:0] got1;

    vecs[0]  = '{5'd0,  32'd1,        32'd2,        32'd3,        1'b0, 1'b0};
    vecs[1]  = '{5'd1,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b1};
    vecs[2]  = '{5'd6,  32'hF,        32'd5,        32'h1E0,      1'b0, 1'b0};
    vecs[3]  = '{5'd9,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
    vecs[4]  = '{5'd12, 32'd0,        32'hF0,       32'hF8,       1'b0, 1'b0};
    vecs[5]  = '{5'd21, 32'd5,        32'd6,        32'd0,        1'b1, 1'b0};
    vecs[6]  = '{5'd8,  32'h80000000, 32'd1,        32'hC0000000, 1'b0, 1'b1};
    vecs[7]  = '{5'd7,  32'h80000000, 32'd1,        32'h40000000, 1'b0, 1'b0};
    vecs[8]  = '{5'd6,  32'd1,        32'd32,       32'd1,        1'b0, 1'b0};
    vecs[9]  = '{5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b1};
    vecs[10] = '{5'd3,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b1};
    vecs[11] = '{5'd4,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0};
    vecs[12] = '{5'd5,  32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[13] = '{5'd9,  32'd5,        32'd3,        32'd0,        1'b1, 1'b0};
    vecs[14] = '{5'd10, 32'h12345678, 32'd9,        32'h12345678, 1'b0, 1'b0};
    vecs[15] = '{5'd11, 32'h12345678, 32'd0,        32'd0,        1'b1, 1'b0};
    vecs[16] = '{5'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
    vecs[17] = '{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
    vecs[18] = '{5'd1,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b1};
    vecs[19] = '{5'd8,  32'h7FFFFFF0, 32'd4,        32'h07FFFFFF, 1'b0, 1'b0};

    reset = 1'b1;
    in_valid = 1'b0;
    opcode = '0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out", out, 32'd0);
    checkOutput("reset z", 32'(z), 32'd0);
    checkOutput("reset n", 32'(n), 32'd0);
    checkOutput("reset dz", 32'(dz), 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);

    // Back-to-back single-cycle ops: one result per cycle.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      opcode = vecs[i].op;
      a = vecs[i].a;
      b = vecs[i].b;
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      checkOutput($sformatf("vec%0d out", i), out, vecs[i].out);
      checkOutput($sformatf("vec%0d z", i), 32'(z), 32'(vecs[i].z));
      checkOutput($sformatf("vec%0d n", i), 32'(n), 32'(vecs[i].n));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle out hold", out, vecs[NV-1].out);

    // MULTU max operands, then read back through MFHI/MFLO.
    applyStimulus(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitResult(cyc, rh);
    checkOutput("mul latency", 32'(cyc), 32'd32);
    checkOutput("mul in_ready while busy", 32'(rh), 32'd0);
    checkOutput("mul out", out, 32'd1);
    checkOutput("mul hi", hi, 32'hFFFFFFFE);
    checkOutput("mul lo", lo, 32'd1);
    checkOutput("mul in_ready at done", 32'(in_ready), 32'd1);
    applyStimulus(5'd15, 32'd0, 32'd0);
    checkOutput("mfhi out_valid", 32'(out_valid), 32'd1);
    checkOutput("mfhi out", out, 32'hFFFFFFFE);
    checkOutput("mfhi n", 32'(n), 32'd1);
    applyStimulus(5'd16, 32'd0, 32'd0);
    checkOutput("mflo out", out, 32'd1);

    applyStimulus(5'd13, 32'h00010000, 32'h00010000);
    waitResult(cyc, rh);
    checkOutput("mul2 hi", hi, 32'd1);
    checkOutput("mul2 lo", lo, 32'd0);
    checkOutput("mul2 z", 32'(z), 32'd1);

    // Operands changed right after accept must not disturb the product.
    applyStimulus(5'd13, 32'd3, 32'd5);
    a = 32'hDEADBEEF;
    b = 32'h0BADF00D;
    waitResult(cyc, rh);
    checkOutput("mul3 hi", hi, 32'd0);
    checkOutput("mul3 lo", lo, 32'd15);

`ifdef ALU_DIV_EN
    applyStimulus(5'd14, 32'd100, 32'd7);
    waitResult(cyc, rh);
    checkOutput("div latency", 32'(cyc), 32'd32);
    checkOutput("div in_ready while busy", 32'(rh), 32'd0);
    checkOutput("div out", out, 32'd14);
    checkOutput("div lo", lo, 32'd14);
    checkOutput("div hi", hi, 32'd2);
    checkOutput("div dz", 32'(dz), 32'd0);
    applyStimulus(5'd14, 32'd5, 32'd0);
    waitResult(cyc, rh);
    checkOutput("div0 latency", 32'(cyc), 32'd32);
    checkOutput("div0 lo", lo, 32'hFFFFFFFF);
    checkOutput("div0 hi", hi, 32'd5);
    checkOutput("div0 dz", 32'(dz), 32'd1);
    checkOutput("div0 n", 32'(n), 32'd1);
    @(posedge clk); #1;
    checkOutput("div0 dz hold", 32'(dz), 32'd1);
    applyStimulus(5'd0, 32'd1, 32'd1);
    checkOutput("post-div0 dz", 32'(dz), 32'd0);
    checkOutput("post-div0 out", out, 32'd2);
`else
    applyStimulus(5'd14, 32'd100, 32'd7);
    checkOutput("nodiv out_valid", 32'(out_valid), 32'd1);
    checkOutput("nodiv out", out, 32'd0);
    checkOutput("nodiv z", 32'(z), 32'd1);
    checkOutput("nodiv dz", 32'(dz), 32'd0);
    checkOutput("nodiv in_ready", 32'(in_ready), 32'd1);
    checkOutput("nodiv hi", hi, 32'd0);
    checkOutput("nodiv lo", lo, 32'd15);
`endif

    // Add held on in_valid during a MULTU: accepted only after completion, exactly once.
    applyStimulus(5'd13, 32'd7, 32'd6);
    in_valid = 1'b1;
    opcode = 5'd0;
    a = 32'd2;
    b = 32'd3;
    pulses = 0;
    got0 = '0;
    got1 = '0;
    for (int c = 0; c < 60; c++) begin
      if (in_valid && in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      if (out_valid) begin
        if (pulses == 0) got0 = out;
        if (pulses == 1) got1 = out;
        pulses++;
      end
    end
    in_valid = 1'b0;
    checkOutput("hold result count", 32'(pulses), 32'd2);
    checkOutput("hold first (mul)", got0, 32'd42);
    checkOutput("hold second (add)", got1, 32'd5);
    checkOutput("hold lo", lo, 32'd42);

    // Reset in the middle of a long operation.
`ifdef ALU_DIV_EN
    applyStimulus(5'd14, 32'd1000, 32'd3);
`else
    applyStimulus(5'd13, 32'd1000, 32'd3);
`endif
    repeat (9) @(posedge clk);
    #1;
    checkOutput("pre-reset in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort hi", hi, 32'd0);
    checkOutput("abort lo", lo, 32'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    checkOutput("abort no result", 32'(pulses), 32'd0);
    applyStimulus(5'd0, 32'd2, 32'd2);
    checkOutput("after abort out_valid", 32'(out_valid), 32'd1);
    checkOutput("after abort out", out, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
